// File: rtl/mul16_shift_add_if.sv
`default_nettype none
// ============================================================================
// Module   : mul16_shift_add_if
// Purpose  : Start/done handshake bundle for the shift-and-add multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface mul16_shift_add_if #(
    parameter int WIDTH = 16
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, a, b, input  busy, done, product);
    modport slave  (input  start, a, b, output busy, done, product);
endinterface
`default_nettype wire

// File: rtl/mul16_shift_add.sv
`default_nettype none
// ============================================================================
// Module   : mul16_shift_add
// Purpose  : Sequential 16x16 unsigned radix-2 shift-and-add multiplier built
//            on four chained 4-bit carry-lookahead slices.
// Revision : 1.0 - initial release
// ============================================================================
module adder4 (
    input  wire logic [3:0] i_x,
    input  wire logic [3:0] i_y,
    input  wire logic       i_cin,
    output logic      [3:0] o_s,
    output logic            o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_x & i_y;
    assign w_p = i_x ^ i_y;

    // Every carry is a flat sum of products of g/p and cin.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_s    = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];
endmodule

module mul16_shift_add #(
    parameter int WIDTH = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mul16_shift_add_if.slave    bus
);
    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;
    localparam logic [3:0] c_LAST = 4'd15;
    localparam int         c_NSLICE = WIDTH / 4;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_acc_hi;
    logic [WIDTH-1:0]     r_acc_lo;
    logic [3:0]           r_cnt;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_busy;
    logic                 w_accept;
    logic                 w_last;
    logic [c_NSLICE:0]    w_carry;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_c;
    logic [WIDTH-1:0]     w_s;
    logic [2*WIDTH-1:0]   w_shifted;

    assign w_carry[0] = 1'b0;
    for (genvar gi = 0; gi < c_NSLICE; gi++) begin : g_slice
        adder4 u_add (
            .i_x    (r_acc_hi[4*gi +: 4]),
            .i_y    (r_mcand[4*gi +: 4]),
            .i_cin  (w_carry[gi]),
            .o_s    (w_sum[4*gi +: 4]),
            .o_cout (w_carry[gi+1])
        );
    end

    assign w_c       = r_acc_lo[0] ? w_carry[c_NSLICE] : 1'b0;
    assign w_s       = r_acc_lo[0] ? w_sum : r_acc_hi;
    // 33-bit right shift: the carry lands in the top bit so it is never lost.
    assign w_shifted = {w_c, w_s, r_acc_lo[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.start)          w_state_nxt = c_RUN;
            c_RUN:   if (r_cnt == c_LAST)    w_state_nxt = c_IDLE;
            default:                         w_state_nxt = c_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_busy   = 1'b0;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            c_IDLE:  w_accept = bus.start;
            c_RUN: begin
                w_busy = 1'b1;
                w_last = (r_cnt == c_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_mcand  <= bus.a;
                r_acc_hi <= '0;
                r_acc_lo <= bus.b;
                r_cnt    <= '0;
            end else if (w_busy) begin
                {r_acc_hi, r_acc_lo} <= w_shifted;
                r_cnt                <= r_cnt + 4'd1;
                if (w_last) begin
                    r_product <= w_shifted;
                end
            end
        end
    end

    assign bus.busy    = w_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule
`default_nettype wire
